// File: rtl/pipelined_shifter_if.sv
// Valid/ready operand and result bundle for pipelined_shifter.
// The master side is the operand producer and result consumer; the slave side is the shifter.
interface pipelined_shifter_if #(
  parameter int N = 32
);
  localparam int S = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipelined_shifter.sv
// S-stage elastic barrel shifter: SLL, SRL, SRA; one shamt bit resolved per registered stage.
// Define PIPELINED_SHIFTER_ROTATE_EN to make op 11 rotate right; otherwise op 11 passes data through.
module pipelined_shifter #(
  parameter int N = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_shifter_if.slave bus
);
  localparam int S = $clog2(N);

  typedef struct packed {
    logic [N-1:0] dat;
    logic [S-1:0] sh;
    logic [1:0]   op;
    logic         sgn;
  } stage_t;

  stage_t       src [S];
  stage_t       nxt [S];
  stage_t       st_p [S];
  logic [S-1:0] src_vld;
  logic [S-1:0] vld_p;
  logic [S-1:0] rdy;

  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input logic sgn,
                                               input logic [1:0] op, input int sh);
    logic [N-1:0] fill;
    logic [N-1:0] res;
    fill = {N{sgn}} << (N - sh);
    case (op)
      2'b00:   res = d << sh;
      2'b01:   res = d >> sh;
      2'b10:   res = (d >> sh) | fill;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      2'b11:   res = (d >> sh) | (d << (N - sh));
`endif
      default: res = d;
    endcase
    return res;
  endfunction

  // Stage inputs: stage 0 is fed from the operand port, stage k from stage k-1.
  always_comb begin
    src[0]     = '{dat: bus.in_data, sh: bus.in_shamt, op: bus.in_op, sgn: bus.in_data[N-1]};
    src_vld[0] = bus.in_valid;
    for (int k = 1; k < S; k++) begin
      src[k]     = st_p[k-1];
      src_vld[k] = vld_p[k-1];
    end
    for (int k = 0; k < S; k++) begin
      nxt[k] = src[k];
      if (src[k].sh[k]) nxt[k].dat = shift_step(src[k].dat, src[k].sgn, src[k].op, 1 << k);
    end
  end

  // A stage can take new content when it, or any stage after it, is empty, or the sink pops.
  // Unrolling the ready chain this way keeps it a flat OR instead of a combinational loop.
  for (genvar k = 0; k < S; k++) begin : g_rdy
    assign rdy[k] = bus.out_ready || !(&vld_p[S-1:k]);
  end

  // Stage registers: data loads only when a valid operand actually moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < S; k++) st_p[k] <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (rdy[k]) begin
          vld_p[k] <= src_vld[k];
          if (src_vld[k]) st_p[k] <= nxt[k];
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_p[S-1];
  assign bus.out_data  = st_p[S-1].dat;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed literals plus randomized streams vs a queue model.
module tb_pipelined_shifter;
  localparam int N = 32;
  localparam int S = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.N(N)) bus ();
  pipelined_shifter #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int           t;
    logic [N-1:0] res;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_pop = 0;
  bit   prev_stall = 0;
  logic [N-1:0] prev_data = '0;
  int   mode = 0;
  bit   ready_lvl = 1'b1;
  int   pidx = 0;
  logic [5:0] pat = 6'b011001;  // bit i is out_ready on cycle i: 1,0,0,1,1,0

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input logic [S-1:0] sh,
                                             input logic [1:0] op);
    logic [2*N-1:0] two;
    logic [N-1:0]   r;
    case (op)
      2'd0: r = d << sh;
      2'd1: r = d >> sh;
      2'd2: r = $unsigned($signed(d) >>> sh);
      default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        two = {d, d} >> sh;
        r   = two[N-1:0];
`else
        two = '0;
        r   = d;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic check_word(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of out_ready: fixed level, repeating pattern, or random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin bus.out_ready = pat[pidx % 6]; pidx++; end
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = ready_lvl;
      endcase
    end
  end

  // Compare process: every negedge, outputs against the acceptance-order model.
  always @(negedge clk) begin
    int  e;
    bit  exp_valid;
    if (!rst_n) begin
      check_bit("reset out_valid", bus.out_valid, 1'b0);
      check_word("reset out_data", bus.out_data, '0);
      q.delete();
      last_pop   = 0;
      prev_stall = 0;
    end else begin
      exp_valid = 0;
      if (q.size() > 0) begin
        e = q[0].t + S - 1;
        if (last_pop > e) e = last_pop;
        exp_valid = (cyc >= e);
      end
      check_bit("out_valid", bus.out_valid, exp_valid);
      if (bus.out_valid && q.size() > 0) check_word("out_data", bus.out_data, q[0].res);
      check_bit("in_ready", bus.in_ready, !(q.size() == S && !bus.out_ready));
      if (prev_stall) begin
        check_bit("stall out_valid", bus.out_valid, 1'b1);
        check_word("stall out_data", bus.out_data, prev_data);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        last_pop = cyc + 1;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back('{t: cyc + 1, res: ref_shift(bus.in_data, bus.in_shamt, bus.in_op)});
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [N-1:0] d, input logic [S-1:0] sh, input logic [1:0] op);
    int w;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_op    = op;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_bit("accept", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = N'($urandom);
  endtask

  task automatic run_one(input logic [N-1:0] d, input logic [S-1:0] sh, input logic [1:0] op,
                         input logic [N-1:0] exp, input string name);
    int n;
    send(d, sh, op);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_bit({name, " valid"}, bus.out_valid, 1'b1);
    check_word(name, bus.out_data, exp);
    check_int({name, " latency"}, n + 1, 5);
    @(negedge clk);
    check_bit({name, " single valid"}, bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    #1;
    check_int(name, q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_op    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_bit("in_ready after reset", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    check_word("model sll", ref_shift(32'h0000_0001, 5'd31, 2'd0), 32'h8000_0000);
    check_word("model sra", ref_shift(32'h8000_0000, 5'd4, 2'd2), 32'hF800_0000);
    check_word("model srl", ref_shift(32'h8000_0000, 5'd4, 2'd1), 32'h0800_0000);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    check_word("model ror", ref_shift(32'h0000_0001, 5'd1, 2'd3), 32'h8000_0000);
`else
    check_word("model op3", ref_shift(32'h0000_0001, 5'd1, 2'd3), 32'h0000_0001);
`endif

    run_one(32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, "sll31");
    run_one(32'h8000_0000, 5'd4, 2'd2, 32'hF800_0000, "sra4");
    run_one(32'h8000_0000, 5'd4, 2'd1, 32'h0800_0000, "srl4");
    for (int op = 0; op < 4; op++) run_one(32'h8000_0000, 5'd0, 2'(op), 32'h8000_0000, "shamt0");
    run_one(32'h1234_5678, 5'd8, 2'd0, 32'h3456_7800, "sll8");
    run_one(32'h7000_0000, 5'd28, 2'd2, 32'h0000_0007, "sra positive");
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    run_one(32'h0000_0001, 5'd1, 2'd3, 32'h8000_0000, "ror1");
    run_one(32'h1234_5678, 5'd12, 2'd3, 32'h6781_2345, "ror12");
`else
    run_one(32'h0000_0001, 5'd1, 2'd3, 32'h0000_0001, "op3 passthru");
`endif

    // Stream with the 1,0,0,1,1,0 out_ready pattern.
    pidx = 0;
    mode = 1;
    for (int i = 0; i < 16; i++) send(N'($urandom), S'($urandom), 2'($urandom));
    drain("pattern drain");
    mode = 0;
    ready_lvl = 1'b1;

    // Random backpressure with random idle gaps.
    mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(N'($urandom), S'($urandom), 2'($urandom));
    end
    drain("random drain");
    mode = 0;

    // Fill with out_ready low, then reset mid-stream.
    ready_lvl = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) send(N'($urandom), S'($urandom), 2'($urandom));
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("full in_ready", bus.in_ready, 1'b0);
    check_bit("full out_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_bit("async reset out_valid", bus.out_valid, 1'b0);
    check_word("async reset out_data", bus.out_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_lvl = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_bit("no stale out_valid", bus.out_valid, 1'b0);
    run_one(32'h0000_00F0, 5'd4, 2'd1, 32'h0000_000F, "post reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, fully pipelined barrel shifter for the ALU datapath. It supports logical left, logical right, arithmetic right and (optionally) rotate right. It resolves one shift-amount bit per registered stage and moves operands through a valid/ready elastic pipeline with full backpressure. It sits between operand fetch and the ALU result mux and is the multi-cycle, multi-mode generation of the single-cycle combinational left shifter.

## Interface
- N, 32, datapath width; power of two, 4..64
- S, $clog2(N), number of pipeline stages (derived; do not override)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block accepts operand this cycle
- in_data  input  N  value to shift
- in_shamt  input  S  shift amount, 0..N-1, unsigned
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  N  shifted result

## Operation
- Transfer on an edge where valid && ready; applies to both ports.
- There are S stages. Stage k (k=0..S-1) holds data, remaining shamt bits, op, sign bit and a valid flag.
- Stage k conditionally shifts by 2^k when shamt bit k is 1. Otherwise it passes data unchanged.
- Stage k registers its result into stage k+1. The output stage is stage S-1's register.
- SLL: fill with zeros from the LSB side.
- SRL: fill with zeros from the MSB side.
- SRA: fill with the captured sign bit, which is in_data[N-1] latched at acceptance and carried through every stage.
- ROR: bits shifted out of the LSB re-enter at the MSB. Requires the config macro.
- Shamt 0 in any mode: out_data == in_data.
- Elastic pipeline rules:
  - A stage advances when the next stage is empty or is advancing itself.
  - The last stage advances when out_ready=1.
  - in_ready = !stage0_valid || stage0_advances. This is a combinational ready chain.
  - No bubbles are inserted while downstream is ready.
- Ordering: results leave in acceptance order. No loss, no duplication.
- While out_valid=1 && out_ready=0, out_data must remain stable.
- A stage whose valid is 0 must not change its data register. This is a power and lint requirement.

## Timing
- Reset (rst_n=0, asynchronous): all stage valids=0, out_valid=0, out_data=0, in_ready=1 from the first edge after deassertion.
- Reset mid-operation: all in-flight operands are discarded immediately. No output is produced for them.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+S-1, and is consumable at edge t+S if out_ready=1. For N=32 that is 5 edges.
- Throughput: 1 operand/cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0 while all S stages are valid.
- Simultaneous pop and push on a full pipeline: both occur on the same edge. Occupancy is unchanged.
- Inputs in_data/in_shamt/in_op are sampled only on an accepting edge. They are don't-care otherwise.

## Configuration
- PIPELINED_SHIFTER_ROTATE_EN
  - Defined: op 11 performs rotate right by in_shamt.
  - Undefined: rotate hardware is omitted, and op 11 is a pass-through (out_data = in_data, same latency and handshake).

## Test plan
- Reset, then in_data=0x0000_0001, shamt=31, op=SLL, out_ready=1 -> after 5 edges out_data=0x8000_0000 with out_valid asserted for exactly 1 cycle.
- in_data=0x8000_0000, shamt=4, op=SRA -> 0xF800_0000. Same operand with op=SRL -> 0x0800_0000. Shamt=0, any op -> 0x8000_0000.
- Macro defined: in_data=0x0000_0001, shamt=1, op=ROR -> 0x8000_0000. Macro undefined: same stimulus -> 0x0000_0001.
- Stream 16 random operands back-to-back while out_ready follows the pattern 1,0,0,1,1,0… -> all 16 results match a reference model in order. out_data is stable during stalls, and in_ready drops only when all 5 stages are valid.
- Fill the pipeline with out_ready=0, then pulse rst_n low mid-stream -> out_valid=0 and out_data=0 immediately. No stale result appears after reset release. The first new operand has 5-edge latency.
